// File: rtl/tree_loader.sv
// tree_loader: receives a framed byte stream of decision-tree node words for
// one channel, checks the frame checksum, and only then writes the buffered
// node words into node memory at channel*MAX_CLUSTERS + k.
module tree_loader #(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int MAX_CLUSTERS    = 5,
    parameter int CHANNEL_COUNT   = 16,
    parameter int WORD_DEPTH      = 24
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            in_valid,
    input  logic [7:0]                                      in_data,
    output logic                                            in_ready,
    output logic                                            mem_ce,
    output logic                                            mem_we,
    output logic [$clog2(MAX_CLUSTERS*CHANNEL_COUNT)-1:0]   mem_a,
    output logic [WORD_DEPTH-1:0]                           mem_d,
    output logic                                            load_done,
    output logic                                            load_error,
    output logic [$clog2(CHANNEL_COUNT)-1:0]                ch_loaded
);

    localparam int WORD_BYTES = WORD_DEPTH / 8;
    localparam int NB         = MAX_CLUSTERS * WORD_BYTES;   // data bytes per frame
    localparam int BUF_W      = MAX_CLUSTERS * WORD_DEPTH;
    localparam int CW         = $clog2(NB);
    localparam int AW         = $clog2(MAX_CLUSTERS * CHANNEL_COUNT);
    localparam int CHW        = $clog2(CHANNEL_COUNT);

    // Node word field boundaries, LSB upward: spare, bias, coeff1, coeff0, mask, flags
    localparam int BIAS_LSB = 1;
    localparam int C1_LSB   = BIAS_LSB + BIAS_BIT_DEPTH;
    localparam int C0_LSB   = C1_LSB + COEFF_BIT_DEPTH;
    localparam int MASK_LSB = C0_LSB + COEFF_BIT_DEPTH;
    localparam int FLAG_LSB = MASK_LSB + FEATURES;

    typedef enum logic [1:0] {
        S_HEADER,
        S_DATA,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;        // data byte index, reused as commit word index
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           chan_q, chan_d;
    logic [BUF_W-1:0]     buf_q, buf_d;        // word 0 ends up in the top WORD_DEPTH bits
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CHW-1:0]       ch_loaded_q, ch_loaded_d;

    logic                 accept;
    logic                 frame_good;
    logic                 commit;
    logic [WORD_DEPTH-1:0] word;

    assign in_ready   = (state_q != S_COMMIT) && !reset;
    assign accept     = in_valid && in_ready;
    assign frame_good = (in_data == csum_q) && (32'(chan_q) < CHANNEL_COUNT);

    // Next-state logic: frame parsing, checksum accumulation and commit sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        chan_d      = chan_q;
        buf_d       = buf_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ch_loaded_d = ch_loaded_q;
        case (state_q)
            S_HEADER: begin
                if (accept) begin
                    chan_d  = in_data;
                    csum_d  = in_data;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    buf_d  = {buf_q[BUF_W-9:0], in_data};
                    csum_d = csum_q ^ in_data;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(NB - 1)) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    cnt_d = '0;
                    if (frame_good) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_HEADER;
                        err_d   = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                // Shift the next word to the top so the write path never indexes the buffer
                buf_d = buf_q << WORD_DEPTH;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MAX_CLUSTERS - 1)) begin
                    state_d     = S_HEADER;
                    done_d      = 1'b1;
                    ch_loaded_d = chan_q[CHW-1:0];
                end
            end
            default: state_d = S_HEADER;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HEADER;
            cnt_q       <= '0;
            csum_q      <= '0;
            chan_q      <= '0;
            buf_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ch_loaded_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            chan_q      <= chan_d;
            buf_q       <= buf_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ch_loaded_q <= ch_loaded_d;
        end
    end

    assign commit = (state_q == S_COMMIT) && !reset;
    assign word   = buf_q[BUF_W-1 -: WORD_DEPTH];

    // Memory write port: active only during COMMIT, all zeros otherwise
    always_comb begin
        mem_ce = 1'b0;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        if (commit) begin
            mem_ce = 1'b1;
            mem_we = 1'b1;
            mem_a  = AW'(ch_loaded_idx(chan_q)) * AW'(MAX_CLUSTERS) + AW'(cnt_q);
            // Stored verbatim; assembled by field to make the layout explicit
            mem_d  = {word[WORD_DEPTH-1:FLAG_LSB], word[FLAG_LSB-1:MASK_LSB],
                      word[MASK_LSB-1:C0_LSB],     word[C0_LSB-1:C1_LSB],
                      word[C1_LSB-1:BIAS_LSB],     word[BIAS_LSB-1:0]};
        end
    end

    function automatic logic [CHW-1:0] ch_loaded_idx(input logic [7:0] ch);
        return ch[CHW-1:0];
    endfunction

    assign load_done  = done_q;
    assign load_error = err_q;
    assign ch_loaded  = ch_loaded_q;

endmodule

// File: doc/tree_loader.md
TREE_LOADER -- requirements
Module: tree_loader

Interface
REQ-001 Parameters (name, default, meaning): FEATURES, 3, features per node; COEFF_BIT_DEPTH, 4, coefficient width; BIAS_BIT_DEPTH, 10, bias width; MAX_CLUSTERS, 5, node words per channel; CHANNEL_COUNT, 16, channels; WORD_DEPTH, 24, memory word width.
REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data is valid.
- in_data, input, 8, config stream byte.
- in_ready, output, 1, byte accepted when in_valid & in_ready.
- mem_ce, output, 1, node memory enable.
- mem_we, output, 1, node memory write strobe.
- mem_a, output, $clog2(MAX_CLUSTERS*CHANNEL_COUNT), word address.
- mem_d, output, WORD_DEPTH, word written.
- load_done, output, 1, one-cycle pulse per committed frame.
- load_error, output, 1, one-cycle pulse per rejected frame.
- ch_loaded, output, $clog2(CHANNEL_COUNT), channel of last committed frame.
REQ-003 One clock domain (clk); reset is synchronous and active-high.

Function
REQ-004 Frame format, in order: 1 header byte (channel = in_data), MAX_CLUSTERS*3 data bytes, 1 checksum byte; total 17 bytes at defaults.
REQ-005 Each node word is 3 bytes, MSB byte first; word k (k = 0..MAX_CLUSTERS-1) is node k.
REQ-006 Word layout, MSB down: child flags [23:22], one-position mask [21:19], coeff0 [18:15], coeff1 [14:11], bias [10:1], bit 0 spare; words are stored verbatim with no field validation.
REQ-007 Checksum: XOR of the header byte and all data bytes; frame is good iff checksum byte equals it AND header < CHANNEL_COUNT.
REQ-008 Data words are buffered internally; no memory write occurs before the checksum byte is accepted.
REQ-009 States:
- HEADER: wait for header byte.
- DATA: accept data bytes.
- CHECK: wait for checksum byte.
- COMMIT: write buffered words to memory.
REQ-010 Transitions:
- HEADER -> DATA on header accept.
- DATA -> CHECK on accept of data byte MAX_CLUSTERS*3-1 (0-based).
- CHECK -> COMMIT on checksum accept when the frame is good.
- CHECK -> HEADER on checksum accept when the frame is bad.
- COMMIT -> HEADER after the last write.
REQ-011 in_ready = 1 in HEADER, DATA and CHECK; 0 in COMMIT and while reset is high.
REQ-012 COMMIT lasts exactly MAX_CLUSTERS cycles. On cycle k: mem_ce = mem_we = 1, mem_a = channel*MAX_CLUSTERS + k, mem_d = word k.
REQ-013 Outside COMMIT: mem_we = 0, mem_ce = 0, mem_a = 0, mem_d = 0.
REQ-014 load_done pulses in the cycle after the last COMMIT write; ch_loaded updates in that same cycle and holds until the next good frame.
REQ-015 Bad frame: load_error pulses in the cycle after checksum accept; no writes; ch_loaded unchanged.
REQ-016 Header >= CHANNEL_COUNT does not abort reception: the full frame is consumed to keep framing, then rejected per REQ-015.
REQ-017 in_valid low mid-frame stalls the block with no timeout; the byte counter and running checksum hold their values.
REQ-018 Frame latency: last byte accept to load_done = MAX_CLUSTERS+1 cycles. Next header can be accepted in the load_done cycle.

Reset
REQ-019 reset = 1 forces state HEADER and clears the byte counter, checksum, buffer, load_done, load_error and ch_loaded to 0. All mem_* outputs are 0.
REQ-020 Reset mid-frame or mid-COMMIT discards the frame; writes not yet issued are never issued, and no done/error pulse is produced.

Verification
REQ-021 Good frame: header 0x02, data bytes 0x01..0x0F, correct checksum -> writes at mem_a 10..14 with mem_d 0x010203, 0x040506, 0x070809, 0x0A0B0C, 0x0D0E0F; load_done 1 cycle later; ch_loaded = 2.
REQ-022 Same frame with checksum bit 0 flipped -> no mem_we; load_error pulse 1 cycle after checksum accept; ch_loaded unchanged.
REQ-023 Header 0x10 with correct XOR -> all 17 bytes accepted; load_error pulses; no writes.
REQ-024 in_valid deasserted 4 cycles between every byte of the good frame -> same writes and values as REQ-021.
REQ-025 Reset asserted on COMMIT cycle 2 -> writes for nodes 3..4 never occur; no load_done; next good frame for channel 15 writes mem_a 75..79.
REQ-026 Back-to-back good frames (ch 0, then ch 1) with in_valid held high -> in_ready is 0 for exactly 5 cycles per frame; addresses 0..4 then 5..9; two load_done pulses.
